// File: rtl/cnn_mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_mac_pkg
//  Description : Shared widths, output limits and FSM encoding for the
//                conv MAC accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_mac_pkg;

  localparam int PROD_W     = 22;
  localparam int OUT_W      = 14;
  localparam int FRAC_SHIFT = 8;
  localparam int ACC_W      = 32;

  localparam int OUT_MAX    = 8191;
  localparam int OUT_MIN    = -8192;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cnn_mac_round_sat.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_mac_round_sat
//  Description : Accumulator to <14,6> conversion: round half up, saturate,
//                optional ReLU. Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module cnn_mac_round_sat
  import cnn_mac_pkg::*;
#(
  parameter bit RELU_EN = 1'b1
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] data,
  output logic             sat
);

  localparam logic signed [ACC_W:0] c_half = (ACC_W+1)'(2 ** (FRAC_SHIFT - 1));
  localparam logic signed [ACC_W:0] c_max  = (ACC_W+1)'(OUT_MAX);
  localparam logic signed [ACC_W:0] c_min  = (ACC_W+1)'(OUT_MIN);

  // One guard bit so the rounding increment can never wrap the sum.
  logic signed [ACC_W:0] w_sum;
  logic signed [ACC_W:0] w_rnd;

  assign w_sum = {acc[ACC_W-1], acc} + c_half;
  assign w_rnd = w_sum >>> FRAC_SHIFT;

  always_comb begin
    data = w_rnd[OUT_W-1:0];
    sat  = 1'b0;
    if (w_rnd > c_max) begin
      data = c_max[OUT_W-1:0];
      sat  = 1'b1;
    end else if (w_rnd < c_min) begin
      data = c_min[OUT_W-1:0];
      sat  = 1'b1;
    end
    // Clipping preserves the sign, so the unclipped sign bit decides ReLU.
    if (RELU_EN && w_rnd[ACC_W]) begin
      data = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cnn_mac_accum.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_mac_accum
//  Description : Accumulates NUM_TERMS conv products onto a bias and emits one
//                rounded/saturated <14,6> pixel per window on valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module cnn_mac_accum
  import cnn_mac_pkg::*;
#(
  parameter int NUM_TERMS = 25,
  parameter bit RELU_EN   = 1'b1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              start,
  input  logic [OUT_W-1:0]  bias_in,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_data,
  output logic              prod_ready,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  output logic              busy
);

  localparam int                CNT_W  = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0]  c_last = CNT_W'(NUM_TERMS - 1);

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;

  logic [ACC_W-1:0]   w_bias_ext;
  logic [ACC_W-1:0]   w_bias_acc;
  logic [ACC_W-1:0]   w_prod_ext;
  logic [OUT_W-1:0]   w_rs_data;
  logic               w_rs_sat;

  assign w_bias_ext = {{(ACC_W-OUT_W){bias_in[OUT_W-1]}}, bias_in};
  assign w_bias_acc = w_bias_ext << FRAC_SHIFT;
  assign w_prod_ext = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};

  cnn_mac_round_sat #(
    .RELU_EN (RELU_EN)
  ) u_round_sat (
    .acc  (r_acc),
    .data (w_rs_data),
    .sat  (w_rs_sat)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      prod_ready <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sat    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc      <= w_bias_acc;
            r_cnt      <= '0;
            prod_ready <= 1'b1;
            busy       <= 1'b1;
            r_state    <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (prod_valid && prod_ready) begin
            r_acc <= r_acc + w_prod_ext;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == c_last) begin
              prod_ready <= 1'b0;
              r_state    <= ST_ROUND;
            end
          end
        end
        ST_ROUND: begin
          out_data  <= w_rs_data;
          out_sat   <= w_rs_sat;
          out_valid <= 1'b1;
          r_state   <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cnn_mac_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnn_mac_accum
//  Description : Directed self-checking bench; a ReLU and a non-ReLU instance
//                share one stimulus stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_mac_accum;

  localparam int NT = 25;

  logic        clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bias_in = '0;
  logic        prod_valid = 1'b0;
  logic [21:0] prod_data = '0;
  logic        out_ready = 1'b0;

  logic        prod_ready, out_valid, out_sat, busy;
  logic [13:0] out_data;
  logic        nr_prod_ready, nr_out_valid, nr_out_sat, nr_busy;
  logic [13:0] nr_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cnn_mac_accum #(.NUM_TERMS(NT), .RELU_EN(1'b1)) u_dut (
    .ap_clk(clk), .ap_rst_n(ap_rst_n), .start(start), .bias_in(bias_in),
    .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(prod_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sat(out_sat), .busy(busy)
  );

  cnn_mac_accum #(.NUM_TERMS(NT), .RELU_EN(1'b0)) u_dut_nr (
    .ap_clk(clk), .ap_rst_n(ap_rst_n), .start(start), .bias_in(bias_in),
    .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(nr_prod_ready),
    .out_ready(out_ready), .out_valid(nr_out_valid), .out_data(nr_out_data),
    .out_sat(nr_out_sat), .busy(nr_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full window; gaps=1 adds random valid gaps, stray start pulses and a 3-cycle out stall.
  task automatic run_window(input string tag, input logic [13:0] bias,
                            input logic [21:0] pb, input logic [21:0] pl, input bit gaps,
                            input logic [13:0] e1, input bit s1,
                            input logic [13:0] e0, input bit s0);
    int n   = 0;
    int cyc = 0;
    bit hs;
    // start with prod_valid high in IDLE: that product must not be taken
    start      = 1'b1;
    bias_in    = bias;
    prod_valid = 1'b1;
    prod_data  = pb;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    while (n < NT && cyc < 1000) begin
      prod_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      prod_data  = (n == NT - 1) ? pl : pb;
      if (gaps && n == 5) begin
        start   = 1'b1;
        bias_in = 14'h1000;
      end else begin
        start = 1'b0;
      end
      if (gaps && !prod_valid) chk({tag, "_rdy_gap"}, prod_ready, 1);
      hs = prod_valid && prod_ready;
      tick();
      cyc++;
      if (hs) n++;
    end
    start      = 1'b0;
    prod_valid = 1'b0;
    if (n < NT) chk({tag, "_timeout"}, n, NT);
    chk({tag, "_k1_valid"}, out_valid, 0);
    chk({tag, "_k1_ready"}, prod_ready, 0);
    tick();
    chk({tag, "_k2_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, e1);
    chk({tag, "_sat"}, out_sat, s1);
    chk({tag, "_nr_data"}, nr_out_data, e0);
    chk({tag, "_nr_sat"}, nr_out_sat, s0);
    if (gaps) begin
      for (int i = 0; i < 3; i++) begin
        start = (i == 1);
        tick();
        chk({tag, "_hold_valid"}, out_valid, 1);
        chk({tag, "_hold_data"}, out_data, e1);
        chk({tag, "_hold_ready"}, prod_ready, 0);
      end
      start = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_done_valid"}, out_valid, 0);
    chk({tag, "_done_busy"}, busy, 0);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_ready", prod_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_busy", busy, 0);
    ap_rst_n = 1'b1;
    tick();

    run_window("c1_unity",   14'h0100, 22'h010000, 22'h010000, 1'b0, 14'h1A00, 1'b0, 14'h1A00, 1'b0);
    run_window("c2_possat",  14'h0000, 22'h020000, 22'h020000, 1'b0, 14'h1FFF, 1'b1, 14'h1FFF, 1'b1);
    run_window("c3_relu",    14'h3F00, 22'h000000, 22'h000000, 1'b0, 14'h0000, 1'b0, 14'h3F00, 1'b0);
    run_window("c4_r80",     14'h0000, 22'h000000, 22'h000080, 1'b0, 14'h0001, 1'b0, 14'h0001, 1'b0);
    run_window("c4_r7f",     14'h0000, 22'h000000, 22'h00007F, 1'b0, 14'h0000, 1'b0, 14'h0000, 1'b0);
    run_window("c4_rm80",    14'h0000, 22'h000000, 22'h3FFF80, 1'b0, 14'h0000, 1'b0, 14'h0000, 1'b0);
    run_window("c4_rm81",    14'h0000, 22'h000000, 22'h3FFF7F, 1'b0, 14'h0000, 1'b0, 14'h3FFF, 1'b0);
    run_window("c4_negsat",  14'h2000, 22'h3E0000, 22'h3E0000, 1'b0, 14'h0000, 1'b1, 14'h2000, 1'b1);
    run_window("c5_stall",   14'h0080, 22'h00C000, 22'h00C000, 1'b1, 14'h1340, 1'b0, 14'h1340, 1'b0);

    // Reset part-way through a window: everything clears asynchronously.
    start   = 1'b1;
    bias_in = 14'h0100;
    tick();
    start      = 1'b0;
    prod_valid = 1'b1;
    prod_data  = 22'h010000;
    repeat (10) tick();
    #2 ap_rst_n = 1'b0;
    #1;
    chk("c6_ready", prod_ready, 0);
    chk("c6_valid", out_valid, 0);
    chk("c6_data", out_data, 0);
    chk("c6_sat", out_sat, 0);
    chk("c6_busy", busy, 0);
    prod_valid = 1'b0;
    repeat (2) tick();
    ap_rst_n = 1'b1;
    tick();
    run_window("c6_after",   14'h0100, 22'h010000, 22'h010000, 1'b0, 14'h1A00, 1'b0, 14'h1A00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
